uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter paired with the existing oversampling receiver, on the same 16x bit-tick clock domain.
- Serialises one DATA_WIDTH-bit word as a burst of back-to-back UART frames, LSB first.
- Each frame is: start bit, frame_length data bits, optional parity bit, then 1 or 2 stop bits.
- Frame format and framing rules match the receiver exactly, so a word sent here is rebuilt whole by the receiver.

Parameters:
- DATA_WIDTH, 32, width of the word per transaction.
- TICKS_PER_BIT, 16, tx_tick cycles per serial bit; fixed at 16 to match receiver oversampling.

Ports:
- tx_tick  input  1  bit-rate x16 tick clock, all logic on posedge.
- PRESET  input  1  asynchronous active-high reset.
- tx_data_in  input  DATA_WIDTH  word to send.
- tx_start  input  1  start request, sampled on posedge tx_tick.
- frame_length  input  4  data bits per frame; legal 5..8.
- stop_bit  input  1  0 = one stop bit, 1 = two stop bits.
- parity  input  2  [1]=enable; 2'b10 odd, 2'b11 even, 2'b0x none.
- TX  output  1  serial line, idle high.
- tx_ready  output  1  high in IDLE; request accepted only when high.
- tx_busy  output  1  high from acceptance until tx_done.
- tx_done  output  1  one-tick pulse after the final stop bit of the word.

Behaviour:
- Reset (async, PRESET=1):
  - TX=1, tx_ready=1, tx_busy=0, tx_done=0.
  - State IDLE; all counters cleared; shift register cleared.
  - Reset mid-frame aborts immediately; TX goes high asynchronously.
- Acceptance: tx_start=1 while tx_ready=1 at a posedge latches tx_data_in, frame_length, stop_bit and parity.
  - Latched configuration is used for the whole word.
  - Input changes during the transfer are ignored.
  - tx_start while busy is ignored; it is not queued.
- frame_length outside 5..8 is treated as 8.
- Frame count: ceil(DATA_WIDTH/frame_length).
  - Word bits go out in index order 0..DATA_WIDTH-1.
  - Bits past DATA_WIDTH-1 in the last frame are sent as 0.
- States:
  - IDLE: TX=1. On accept, go to START on the next tick.
  - START: TX=0 for 16 ticks.
  - DATA: frame_length bits, 16 ticks each. When the bit counter reaches frame_length-1 and tick=15, go to PARITY if parity[1]=1, else STOP1.
  - PARITY: 16 ticks.
    - 2'b11 (even): bit = XOR of the frame's data bits.
    - 2'b10 (odd): bit = XNOR of the frame's data bits.
    - Padding bits are included in the calculation.
  - STOP1: TX=1 for 16 ticks. At tick 15:
    - stop_bit=1: go to STOP2.
    - else, frames remain: go to START.
    - else: go to DONE.
  - STOP2: TX=1 for 16 ticks; then START if frames remain, else DONE.
  - DONE: tx_done=1 for exactly one tick, TX=1, then IDLE.
    - tx_ready returns high on the tick after DONE.
    - Earliest next acceptance is in that IDLE tick.
- Timing:
  - TX is registered.
  - The first start bit begins one tick after the accepting edge.
  - No idle gap between frames of the same word.
  - Every bit lasts exactly 16 ticks.
- Tick counter: 4-bit, wraps 15->0 at each bit boundary. The bit counter clears at every frame start.
- The word index counter must not exceed DATA_WIDTH+7. It clears in IDLE.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- When defined:
  - Adds input CTS (1 bit, active-high clear-to-send).
  - At each frame boundary (entering START), if CTS=0, the block holds TX=1 in a WAIT_CTS state until CTS=1, then starts the frame on the next tick.
  - A frame already in progress always completes.
  - tx_busy stays high during WAIT_CTS.
- When undefined: no CTS port and no WAIT_CTS state; frames are always back-to-back.

Test Plan:
- Case 1: DATA_WIDTH=32, word 0x000000A5, frame_length=8, parity=2'b00, stop_bit=0.
  - Required: 4 frames, 640 ticks from first start bit to tx_done.
  - Frame0 data LSB-first is 1,0,1,0,0,1,0,1.
  - Loopback receiver yields 0x000000A5 with prx_error=0.
- Case 2: same word, parity=2'b11 then 2'b10, stop_bit=1.
  - Required: frame0 parity bit 0 (even) and 1 (odd).
  - 768 ticks total; receiver reports no error.
- Case 3: frame_length=5, word 0xFFFFFFFF, parity even.
  - Required: 7 frames.
  - Last frame data 1,1,0,0,0 with parity bit 0.
- Case 4: assert PRESET at tick 300 of a transfer.
  - Required: TX=1 immediately; tx_busy=0, tx_ready=1, no tx_done.
  - A new tx_start after release transmits correctly.
- Case 5: pulse tx_start while busy with a different word.
  - Required: ignored; only the first word is sent.
  - Exactly one tx_done pulse of width 1 tick.
- Case 6 (UART_TX_CTS_EN): drop CTS during frame1 data.
  - Required: frame1 completes; TX holds 1 until CTS rises; frame2 start bit begins one tick later.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter that serialises one DATA_WIDTH-bit word as a
// burst of back-to-back frames (start, 5..8 data bits LSB first, optional
// parity, 1 or 2 stop bits) on the 16x oversampling tick domain.
// Optional build macro: UART_TX_CTS_EN adds a CTS input and a WAIT_CTS state
// that holds the line idle at frame boundaries until the receiver is ready.
module uart_tx_frame #(
    parameter int DATA_WIDTH    = 32,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic                  tx_tick,
    input  logic                  PRESET,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic                  tx_start,
    input  logic [3:0]            frame_length,
    input  logic                  stop_bit,
    input  logic [1:0]            parity,
`ifdef UART_TX_CTS_EN
    input  logic                  CTS,
`endif
    output logic                  TX,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int          IW        = $clog2(DATA_WIDTH + 8);
    localparam logic [3:0]  LAST_TICK = 4'(TICKS_PER_BIT - 1);
    localparam logic [IW-1:0] WORD_END = IW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_DONE
`ifdef UART_TX_CTS_EN
        , S_WAIT_CTS
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            tick_q, tick_d;
    logic [2:0]            bit_q, bit_d;
    logic [2:0]            last_q, last_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_acc_q, par_acc_d;
    logic [1:0]            par_cfg_q, par_cfg_d;
    logic                  stop_q, stop_d;
    logic                  tx_q, tx_d;

    logic                  bit_end;
    logic                  frames_left;
    state_t                frame_entry;

    assign bit_end     = (tick_q == LAST_TICK);
    assign frames_left = (idx_q < WORD_END);

    // Every new frame enters through START, or waits for clear-to-send first
`ifdef UART_TX_CTS_EN
    assign frame_entry = CTS ? S_START : S_WAIT_CTS;
`else
    assign frame_entry = S_START;
`endif

    // Next-state, counters and the registered line value for the state being entered
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        last_d    = last_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        par_cfg_d = par_cfg_q;
        stop_d    = stop_q;
        tx_d      = 1'b1;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                idx_d  = '0;
                if (tx_start) begin
                    shift_d   = tx_data_in;
                    last_d    = (frame_length >= 4'd5 && frame_length <= 4'd8) ?
                                3'(frame_length - 4'd1) : 3'd7;
                    stop_d    = stop_bit;
                    par_cfg_d = parity;
                    par_acc_d = 1'b0;
                    state_d   = frame_entry;
                end
            end
            S_START: begin
                tick_d    = tick_q + 4'd1;
                bit_d     = '0;
                par_acc_d = 1'b0;
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                tick_d = tick_q + 4'd1;
                if (bit_end) begin
                    // Shifting in zeros past the word end yields the padding bits
                    shift_d   = shift_q >> 1;
                    par_acc_d = par_acc_q ^ shift_q[0];
                    idx_d     = idx_q + IW'(1);
                    if (bit_q == last_q) begin
                        state_d = par_cfg_q[1] ? S_PARITY : S_STOP1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                tick_d = tick_q + 4'd1;
                if (bit_end) state_d = S_STOP1;
            end
            S_STOP1: begin
                tick_d = tick_q + 4'd1;
                if (bit_end) begin
                    if (stop_q)           state_d = S_STOP2;
                    else if (frames_left) state_d = frame_entry;
                    else                  state_d = S_DONE;
                end
            end
            S_STOP2: begin
                tick_d = tick_q + 4'd1;
                if (bit_end) state_d = frames_left ? frame_entry : S_DONE;
            end
            S_DONE: begin
                tick_d  = '0;
                state_d = S_IDLE;
            end
`ifdef UART_TX_CTS_EN
            S_WAIT_CTS: begin
                tick_d = '0;
                if (CTS) state_d = S_START;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_cfg_q[0] ? par_acc_d : ~par_acc_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces the line idle immediately
    always_ff @(posedge tx_tick or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            last_q    <= 3'd7;
            idx_q     <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            par_cfg_q <= '0;
            stop_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_acc_q <= par_acc_d;
            par_cfg_q <= par_cfg_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
        end
    end

    assign TX       = tx_q;
    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: checks uart_tx_frame against a bit-list model of the
// serial line built from the framing rules. Optional build macro
// UART_TX_CTS_EN enables the clear-to-send flow-control case.
module tb_uart_tx_frame;

    localparam int DW = 32;

    logic          tx_tick = 1'b0;
    logic          PRESET  = 1'b1;
    logic [DW-1:0] tx_data_in = '0;
    logic          tx_start = 1'b0;
    logic [3:0]    frame_length = 4'd8;
    logic          stop_bit = 1'b0;
    logic [1:0]    parity = 2'b00;
    logic          cts = 1'b1;
    logic          TX, tx_ready, tx_busy, tx_done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    bit          exp_bits[$];
    bit          mactive = 1'b0;
    bit          free_run = 1'b0;
    int unsigned mpos = 0;
    int unsigned mtotal = 0;

    uart_tx_frame #(.DATA_WIDTH(DW), .TICKS_PER_BIT(16)) dut (
        .tx_tick      (tx_tick),
        .PRESET       (PRESET),
        .tx_data_in   (tx_data_in),
        .tx_start     (tx_start),
        .frame_length (frame_length),
        .stop_bit     (stop_bit),
        .parity       (parity),
`ifdef UART_TX_CTS_EN
        .CTS          (cts),
`endif
        .TX           (TX),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    // 16x bit-rate tick
    always #5 tx_tick = ~tx_tick;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected line value per bit period for one whole word
    task automatic build_model(input logic [DW-1:0] word, input logic [3:0] fl,
                               input logic [1:0] par, input logic stp);
        int unsigned flen, nfr, idx;
        bit x, bt;
        flen = (fl < 5 || fl > 8) ? 8 : int'(fl);
        nfr  = (DW + flen - 1) / flen;
        exp_bits.delete();
        for (int unsigned f = 0; f < nfr; f++) begin
            exp_bits.push_back(1'b0);
            x = 1'b0;
            for (int unsigned b = 0; b < flen; b++) begin
                idx = f * flen + b;
                bt  = (idx < DW) ? word[idx] : 1'b0;
                x   = x ^ bt;
                exp_bits.push_back(bt);
            end
            if (par[1]) exp_bits.push_back(par[0] ? x : ~x);
            exp_bits.push_back(1'b1);
            if (stp) exp_bits.push_back(1'b1);
        end
        mtotal = exp_bits.size() * 16;
    endtask

    // Per-tick comparison of all outputs against the model
    always @(negedge tx_tick) begin
        if (!PRESET && !free_run) begin
            if (mactive) begin
                if (mpos < mtotal) begin
                    chk("tx_line", TX, exp_bits[mpos / 16]);
                    chk("busy", tx_busy, 1);
                    chk("ready", tx_ready, 0);
                    chk("done_early", tx_done, 0);
                end else if (mpos == mtotal) begin
                    chk("done_pulse", tx_done, 1);
                    chk("done_tx", TX, 1);
                    chk("done_ready", tx_ready, 0);
                end else begin
                    chk("end_ready", tx_ready, 1);
                    chk("end_busy", tx_busy, 0);
                    chk("end_done", tx_done, 0);
                    chk("end_tx", TX, 1);
                    mactive = 1'b0;
                end
                mpos++;
            end else begin
                chk("idle_tx", TX, 1);
                chk("idle_ready", tx_ready, 1);
                chk("idle_busy", tx_busy, 0);
                chk("idle_done", tx_done, 0);
            end
        end
    end

    task automatic accept(input logic [DW-1:0] word, input logic [3:0] fl,
                          input logic [1:0] par, input logic stp);
        @(negedge tx_tick);
        tx_data_in = word; frame_length = fl; parity = par; stop_bit = stp;
        tx_start = 1'b1;
        @(posedge tx_tick);
        #1;
        build_model(word, fl, par, stp);
        mpos = 0;
        mactive = 1'b1;
        tx_start = 1'b0;
    endtask

    // Wait for the model to finish; optionally scramble inputs and poke tx_start meanwhile
    task automatic finish_word(input bit disturb);
        int unsigned n = 0;
        while (mactive && n < 4000) begin
            @(negedge tx_tick);
            n++;
            if (disturb && mpos + 3 < mtotal) begin
                tx_data_in   = $urandom;
                frame_length = 4'($urandom_range(0, 15));
                parity       = 2'($urandom_range(0, 3));
                stop_bit     = 1'($urandom_range(0, 1));
                tx_start     = 1'($urandom_range(0, 1));
            end else begin
                tx_start = 1'b0;
            end
        end
        tx_start = 1'b0;
        chk("word_timeout", {31'd0, mactive}, 0);
        mactive = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] word, input logic [3:0] fl,
                        input logic [1:0] par, input logic stp, input bit disturb);
        accept(word, fl, par, stp);
        finish_word(disturb);
    endtask

    initial begin : main
        logic [7:0] byte0;
        logic [4:0] last5;

        // Hand-derived values that pin the model
        build_model(32'h000000A5, 4'd8, 2'b00, 1'b0);
        chk("m_case1_ticks", mtotal, 640);
        for (int i = 0; i < 8; i++) byte0[i] = exp_bits[1 + i];
        chk("m_case1_frame0", byte0, 8'hA5);
        build_model(32'h000000A5, 4'd8, 2'b11, 1'b1);
        chk("m_case2_ticks", mtotal, 768);
        chk("m_case2_even", exp_bits[9], 0);
        build_model(32'h000000A5, 4'd8, 2'b10, 1'b1);
        chk("m_case2_odd", exp_bits[9], 1);
        build_model(32'hFFFFFFFF, 4'd5, 2'b11, 1'b0);
        chk("m_case3_frames", exp_bits.size(), 7 * 8);
        for (int i = 0; i < 5; i++) last5[i] = exp_bits[49 + i];
        chk("m_case3_last", last5, 5'b00011);
        chk("m_case3_par", exp_bits[54], 0);
        build_model(32'h0, 4'd2, 2'b00, 1'b0);
        chk("m_fl_clamp", mtotal, 640);

        // Reset state
        #12;
        chk("rst_tx", TX, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        @(negedge tx_tick);
        PRESET = 1'b0;
        repeat (3) @(negedge tx_tick);

        // Directed cases
        send(32'h000000A5, 4'd8, 2'b00, 1'b0, 1'b0);
        send(32'h000000A5, 4'd8, 2'b11, 1'b1, 1'b0);
        send(32'h000000A5, 4'd8, 2'b10, 1'b1, 1'b0);
        send(32'hFFFFFFFF, 4'd5, 2'b11, 1'b0, 1'b0);

        // Reset in the middle of a word
        accept(32'h12345678, 4'd7, 2'b10, 1'b0);
        repeat (300) @(posedge tx_tick);
        #2;
        PRESET = 1'b1;
        mactive = 1'b0;
        #1;
        chk("mid_rst_tx", TX, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_done", tx_done, 0);
        @(negedge tx_tick);
        PRESET = 1'b0;
        repeat (2) @(negedge tx_tick);
        send(32'hC3A55A3C, 4'd6, 2'b11, 1'b1, 1'b0);

        // tx_start while busy with a different word is ignored
        accept(32'hDEADBEEF, 4'd8, 2'b00, 1'b0);
        repeat (100) @(negedge tx_tick);
        tx_data_in = 32'h0F0F0F0F;
        tx_start = 1'b1;
        @(negedge tx_tick);
        tx_start = 1'b0;
        finish_word(1'b0);

        // Random words, formats and mid-word input noise
        for (int t = 0; t < 14; t++) begin
            send($urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge tx_tick);
        end

`ifdef UART_TX_CTS_EN
        // Flow control: drop CTS during frame1 data
        begin : cts_case
            int unsigned n;
            @(negedge tx_tick);
            free_run = 1'b1;
            tx_data_in = 32'h000000A5; frame_length = 4'd8; parity = 2'b00; stop_bit = 1'b0;
            tx_start = 1'b1;
            @(posedge tx_tick);
            #1 tx_start = 1'b0;
            repeat (200) @(negedge tx_tick);
            cts = 1'b0;
            repeat (100) @(negedge tx_tick);
            chk("cts_frame1_runs", tx_busy, 1);
            repeat (40) @(negedge tx_tick);
            chk("cts_hold_tx", TX, 1);
            chk("cts_hold_busy", tx_busy, 1);
            repeat (30) @(negedge tx_tick);
            chk("cts_hold_tx2", TX, 1);
            cts = 1'b1;
            @(negedge tx_tick);
            chk("cts_restart", TX, 0);
            n = 0;
            while (!tx_done && n < 1000) begin
                @(negedge tx_tick);
                n++;
            end
            chk("cts_done", tx_done, 1);
            @(negedge tx_tick);
            free_run = 1'b0;
        end
`endif

        repeat (3) @(negedge tx_tick);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
